// File: rtl/dma_pkg.sv
// Shared types and constants for the two-channel DMA scheduler.
package dma_pkg;

  localparam int unsigned NUM_DMA_CH     = 2;
  localparam int unsigned DMA_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } dma_state_e;

  // remain is held at full 32-bit width; only the low LEN_W bits are ever non-zero.
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] remain;
    logic        fix_src;
    logic        busy;
  } dma_chan_cfg_t;

endpackage

// File: rtl/dma_rr_arb.sv
// Two-input round-robin arbiter: on contention the channel that did not
// go last wins; a lone requester always wins. Grant is one-hot.
module dma_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    else              grant = req;
  end

endmodule

// File: rtl/dma_chan_sched.sv
// Two-channel DMA scheduler: round-robin per word, each word is a read from
// src followed by a write to dst through the single bus-master port.
module dma_chan_sched
  import dma_pkg::*;
#(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned ADDR_INC = DMA_WORD_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         ch_start,
  input  logic [1:0]         ch_abort,
  input  logic [63:0]        ch_src,
  input  logic [63:0]        ch_dst,
  input  logic [2*LEN_W-1:0] ch_len,
  input  logic [1:0]         ch_fix_src,
  output logic [1:0]         ch_busy,
  output logic [1:0]         ch_done,
  output logic [2*LEN_W-1:0] ch_remain,
  output logic               mst_req,
  output logic               mst_we,
  output logic [31:0]        mst_addr,
  output logic [31:0]        mst_wdata,
  input  logic               mst_ack,
  input  logic [31:0]        mst_rdata
);

  dma_state_e    state, state_d;
  dma_chan_cfg_t cfg [NUM_DMA_CH];
  logic          gnt, gnt_d;
  logic          rr_last;
  logic [1:0]    abort_pend;
  logic [1:0]    done_q;
  logic [1:0]    arb_req, arb_grant;
  logic [1:0]    in_flight;
  logic          req_d, we_d;
  logic [31:0]   addr_d, wdata_d;
  logic          word_done;

  // A channel being aborted this cycle must not be granted a new word.
  always_comb begin
    arb_req   = '0;
    in_flight = '0;
    for (int unsigned i = 0; i < NUM_DMA_CH; i++) begin
      arb_req[i[0]] = cfg[i[0]].busy & ~ch_abort[i[0]];
    end
    if (state != IDLE) in_flight[gnt] = 1'b1;
  end

  dma_rr_arb u_arb (
    .req   (arb_req),
    .last  (rr_last),
    .grant (arb_grant)
  );

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    req_d     = mst_req;
    we_d      = mst_we;
    addr_d    = mst_addr;
    wdata_d   = mst_wdata;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        if (|arb_grant) begin
          gnt_d   = arb_grant[1];
          state_d = RD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = cfg[arb_grant[1]].src;
        end
      end
      RD: begin
        if (mst_ack) begin
          state_d = WR;
          we_d    = 1'b1;
          addr_d  = cfg[gnt].dst;
          wdata_d = mst_rdata;
        end
      end
      WR: begin
        if (mst_ack) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          word_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rr_last   <= 1'b1;
      mst_req   <= 1'b0;
      mst_we    <= 1'b0;
      mst_addr  <= '0;
      mst_wdata <= '0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      mst_req   <= req_d;
      mst_we    <= we_d;
      mst_addr  <= addr_d;
      mst_wdata <= wdata_d;
      if (word_done) rr_last <= gnt;
    end
  end

  // An abort on the granted channel is deferred until its write completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DMA_CH; i++) cfg[i[0]] <= '0;
      abort_pend <= '0;
      done_q     <= '0;
    end else begin
      done_q <= '0;
      for (int unsigned i = 0; i < NUM_DMA_CH; i++) begin
        if (cfg[i[0]].busy) begin
          if (in_flight[i[0]] && word_done) begin
            if (!cfg[i[0]].fix_src) cfg[i[0]].src <= cfg[i[0]].src + ADDR_INC;
            cfg[i[0]].dst    <= cfg[i[0]].dst + ADDR_INC;
            cfg[i[0]].remain <= cfg[i[0]].remain - 32'd1;
            if (cfg[i[0]].remain == 32'd1 || abort_pend[i[0]] || ch_abort[i[0]]) begin
              cfg[i[0]].busy    <= 1'b0;
              done_q[i[0]]      <= 1'b1;
              abort_pend[i[0]]  <= 1'b0;
            end
          end else if (ch_abort[i[0]]) begin
            if (in_flight[i[0]]) begin
              abort_pend[i[0]] <= 1'b1;
            end else begin
              cfg[i[0]].busy <= 1'b0;
              done_q[i[0]]   <= 1'b1;
            end
          end
        end else if (ch_start[i[0]] && !ch_abort[i[0]]) begin
          if (ch_len[i*LEN_W +: LEN_W] == '0) begin
            done_q[i[0]] <= 1'b1;
          end else begin
            cfg[i[0]].src     <= ch_src[i*32 +: 32];
            cfg[i[0]].dst     <= ch_dst[i*32 +: 32];
            cfg[i[0]].remain  <= 32'(ch_len[i*LEN_W +: LEN_W]);
            cfg[i[0]].fix_src <= ch_fix_src[i[0]];
            cfg[i[0]].busy    <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ch_busy   = '0;
    ch_remain = '0;
    for (int unsigned i = 0; i < NUM_DMA_CH; i++) begin
      ch_busy[i[0]]              = cfg[i[0]].busy;
      ch_remain[i*LEN_W +: LEN_W] = cfg[i[0]].remain[LEN_W-1:0];
    end
  end

  assign ch_done = done_q;

endmodule

// File: tb/tb_dma_chan_sched.sv
// Self-checking bench for dma_chan_sched: table-driven single-channel runs plus
// hand-written arbitration, abort and reset sequences, with an access scoreboard.
module tb_dma_chan_sched;

  localparam int unsigned LEN_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         ch_start = '0;
  logic [1:0]         ch_abort = '0;
  logic [63:0]        ch_src = '0;
  logic [63:0]        ch_dst = '0;
  logic [2*LEN_W-1:0] ch_len = '0;
  logic [1:0]         ch_fix_src = '0;
  logic [1:0]         ch_busy, ch_done;
  logic [2*LEN_W-1:0] ch_remain;
  logic               mst_req, mst_we, mst_ack;
  logic [31:0]        mst_addr, mst_wdata, mst_rdata;

  always #5 clk = ~clk;

  dma_chan_sched #(.LEN_W(LEN_W), .ADDR_INC(4)) dut (
    .clk(clk), .rst(rst), .ch_start(ch_start), .ch_abort(ch_abort),
    .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len), .ch_fix_src(ch_fix_src),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_remain(ch_remain),
    .mst_req(mst_req), .mst_we(mst_we), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_ack(mst_ack), .mst_rdata(mst_rdata)
  );

  typedef struct {
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      data;
    int               ch;
    logic [LEN_W-1:0] rem;
  } acc_t;

  typedef struct {
    int               ch;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             fix;
    int               exp_words;
    logic [31:0]      exp_last_rd;
    logic [1:0]       exp_done_hot;
  } vec_t;

  acc_t        sb[$];
  int          done_order[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt[2] = '{0, 0};
  int          wr_cnt = 0;
  int          req_seen = 0;
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus master model: acks each access 2 cycles after it is presented.
  initial begin
    acc_t e;
    int   wcnt;
    wcnt      = 0;
    mst_ack   = 1'b0;
    mst_rdata = '0;
    forever begin
      @(negedge clk);
      mst_ack = 1'b0;
      if (rst || !mst_req) begin
        wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt    = 0;
          mst_ack = 1'b1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: got we=%0b addr=%0h expected no access", mst_we, mst_addr);
          end else begin
            e = sb.pop_front();
            check("access_we_addr", {31'b0, mst_we, mst_addr}, {31'b0, e.we, e.addr});
            if (e.we) begin
              check("write_data", mst_wdata, e.data);
              check("remain_at_write", ch_remain[e.ch*LEN_W +: LEN_W], e.rem);
              wr_cnt++;
            end
          end
          if (!mst_we) begin
            mst_rdata = rd_fn(mst_addr);
            last_rd   = mst_addr;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mst_req) req_seen++;
    for (int i = 0; i < 2; i++) begin
      if (ch_done[i]) begin
        done_cnt[i]++;
        done_order.push_back(i);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_start = '0;
    ch_abort = '0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    tick();
  endtask

  task automatic load(input int ch, input logic [31:0] s, input logic [31:0] d,
                      input logic [LEN_W-1:0] len, input logic fix);
    ch_src[ch*32 +: 32]       = s;
    ch_dst[ch*32 +: 32]       = d;
    ch_len[ch*LEN_W +: LEN_W] = len;
    ch_fix_src[ch]            = fix;
  endtask

  task automatic push_word(input int ch, input logic [31:0] s, input logic [31:0] d,
                           input logic [LEN_W-1:0] rem);
    acc_t e;
    e.we = 1'b0; e.addr = s; e.data = '0; e.ch = ch; e.rem = rem;
    sb.push_back(e);
    e.we = 1'b1; e.addr = d; e.data = rd_fn(s);
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (ch_busy == 2'b00 && !mst_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%b req=%b expected idle", name, ch_busy, mst_req);
    end
  endtask

  task automatic wait_acc(input string name, input logic we, input logic [31:0] addr);
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (mst_req && mst_we == we && mst_addr == addr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got req=%b addr=%0h expected access at %0h", name, mst_req, mst_addr, addr);
    end
  endtask

  initial begin
    vec_t        vt[5];
    int          d0, d1, w0, r0, ch;
    logic [31:0] s, d;

    vt[0] = '{0, 32'h0000_1000, 32'h0000_2000, 16'd3, 1'b0, 3, 32'h0000_1008, 2'b00};
    vt[1] = '{1, 32'h0000_3000, 32'h0000_4000, 16'd4, 1'b1, 4, 32'h0000_3000, 2'b00};
    vt[2] = '{0, 32'h0000_1100, 32'h0000_2100, 16'd0, 1'b0, 0, 32'h0000_0000, 2'b01};
    vt[3] = '{1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 1'b0, 3, 32'h0000_0000, 2'b00};
    vt[4] = '{0, 32'h0000_0010, 32'h0000_0020, 16'd1, 1'b0, 1, 32'h0000_0010, 2'b00};

    tick();
    tick();
    check("reset_state", {ch_busy, ch_done, ch_remain, mst_req, mst_we}, '0);
    check("reset_bus", {mst_addr, mst_wdata}, '0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      ch = vt[v].ch;
      d0 = done_cnt[ch];
      w0 = wr_cnt;
      r0 = req_seen;
      load(ch, vt[v].src, vt[v].dst, vt[v].len, vt[v].fix);
      s = vt[v].src;
      d = vt[v].dst;
      for (int k = 0; k < int'(vt[v].len); k++) begin
        push_word(ch, s, d, vt[v].len - LEN_W'(k));
        if (!vt[v].fix) s = s + 32'd4;
        d = d + 32'd4;
      end
      ch_start[ch] = 1'b1;
      tick();
      ch_start = '0;
      if (vt[v].len == '0) begin
        check("len0_done_next_cycle", ch_done, vt[v].exp_done_hot);
        check("len0_not_busy", ch_busy, 2'b00);
      end else begin
        check("start_busy_remain", {ch_busy[ch], ch_remain[ch*LEN_W +: LEN_W]}, {1'b1, vt[v].len});
      end
      wait_idle("vec");
      tick();
      check("vec_done_once", done_cnt[ch] - d0, 1);
      check("vec_words", wr_cnt - w0, vt[v].exp_words);
      if (vt[v].exp_words > 0) check("vec_last_read", last_rd, vt[v].exp_last_rd);
      else                     check("vec_no_req", req_seen - r0, 0);
      check("vec_remain_end", ch_remain[ch*LEN_W +: LEN_W], 0);
      check("vec_sb_empty", sb.size(), 0);
    end

    // Both channels started together: words alternate ch0, ch1, ch0, ch1.
    do_reset();
    load(0, 32'h5000, 32'h6000, 16'd2, 1'b0);
    load(1, 32'h7000, 32'h8000, 16'd2, 1'b0);
    push_word(0, 32'h5000, 32'h6000, 16'd2);
    push_word(1, 32'h7000, 32'h8000, 16'd2);
    push_word(0, 32'h5004, 32'h6004, 16'd1);
    push_word(1, 32'h7004, 32'h8004, 16'd1);
    done_order.delete();
    ch_start = 2'b11;
    tick();
    ch_start = '0;
    wait_idle("rr");
    tick();
    check("rr_sb_empty", sb.size(), 0);
    check("rr_done_count", done_order.size(), 2);
    if (done_order.size() == 2) begin
      check("rr_done_first", done_order[0], 0);
      check("rr_done_second", done_order[1], 1);
    end

    // Abort of a waiting (not granted) channel completes at once.
    do_reset();
    load(0, 32'h5100, 32'h6100, 16'd2, 1'b0);
    load(1, 32'h7100, 32'h8100, 16'd2, 1'b0);
    push_word(0, 32'h5100, 32'h6100, 16'd2);
    push_word(0, 32'h5104, 32'h6104, 16'd1);
    d1 = done_cnt[1];
    ch_start = 2'b11;
    tick();
    ch_start = '0;
    wait_acc("abort_idle_wait", 1'b0, 32'h5100);
    ch_abort = 2'b10;
    tick();
    ch_abort = '0;
    check("abort_idle_done", ch_done, 2'b10);
    check("abort_idle_busy", ch_busy, 2'b01);
    wait_idle("abort_idle");
    tick();
    check("abort_idle_sb_empty", sb.size(), 0);
    check("abort_idle_done_once", done_cnt[1] - d1, 1);

    // Abort of the granted channel during the read of word 2 of 5.
    load(0, 32'h9000, 32'hA000, 16'd5, 1'b0);
    push_word(0, 32'h9000, 32'hA000, 16'd5);
    push_word(0, 32'h9004, 32'hA004, 16'd4);
    d0 = done_cnt[0];
    ch_start = 2'b01;
    tick();
    ch_start = '0;
    wait_acc("abort_rd_wait", 1'b0, 32'h9004);
    ch_abort = 2'b01;
    tick();
    ch_abort = '0;
    wait_idle("abort_rd");
    tick();
    tick();
    tick();
    check("abort_rd_done_once", done_cnt[0] - d0, 1);
    check("abort_rd_remain", ch_remain[0 +: LEN_W], 3);
    check("abort_rd_sb_empty", sb.size(), 0);
    check("abort_rd_idle", {ch_busy, mst_req}, 0);

    // Start and abort in the same cycle: nothing happens.
    load(1, 32'h0100, 32'h0200, 16'd2, 1'b0);
    d1 = done_cnt[1];
    r0 = req_seen;
    ch_start = 2'b10;
    ch_abort = 2'b10;
    tick();
    ch_start = '0;
    ch_abort = '0;
    tick();
    tick();
    check("start_abort_busy", ch_busy, 2'b00);
    check("start_abort_no_done", done_cnt[1] - d1, 0);
    check("start_abort_no_req", req_seen - r0, 0);

    // Reset asserted during a write access, then a normal transfer.
    load(1, 32'hB000, 32'hC000, 16'd3, 1'b0);
    push_word(1, 32'hB000, 32'hC000, 16'd3);
    d1 = done_cnt[1];
    ch_start = 2'b10;
    tick();
    ch_start = '0;
    wait_acc("rst_wr_wait", 1'b1, 32'hC000);
    rst = 1'b1;
    #1;
    check("rst_in_wr_drops", {mst_req, ch_busy}, 0);
    tick();
    tick();
    sb.delete();
    check("rst_in_wr_no_done", done_cnt[1] - d1, 0);
    rst = 1'b0;
    tick();
    load(0, 32'hD000, 32'hE000, 16'd2, 1'b0);
    push_word(0, 32'hD000, 32'hE000, 16'd2);
    push_word(0, 32'hD004, 32'hE004, 16'd1);
    d0 = done_cnt[0];
    ch_start = 2'b01;
    tick();
    ch_start = '0;
    wait_idle("post_rst");
    tick();
    check("post_rst_done", done_cnt[0] - d0, 1);
    check("post_rst_sb_empty", sb.size(), 0);
    check("post_rst_last_read", last_rd, 32'hD004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
